// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: instruction-memory read port plus the core-facing instruction stream.
// master = fetch unit, slave = memory/core environment.
interface fetch_prefetch_queue_if #(
    parameter int p_WORD_LEN = 16,
    parameter int p_ADDR_LEN = 16,
    parameter int p_DEPTH    = 4
);
    localparam int CW = $clog2(p_DEPTH) + 1;

    logic                  o_imem_req;
    logic [p_ADDR_LEN-1:0] o_imem_addr;
    logic [p_WORD_LEN-1:0] i_imem_data;
    logic                  i_stall;
    logic                  i_redirect;
    logic [p_ADDR_LEN-1:0] i_redirect_pc;
    logic [p_WORD_LEN-1:0] o_inst;
    logic [p_ADDR_LEN-1:0] o_inst_pc;
    logic                  o_inst_valid;
    logic [CW-1:0]         o_count;

    modport master (
        output o_imem_req, o_imem_addr, o_inst, o_inst_pc, o_inst_valid, o_count,
        input  i_imem_data, i_stall, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_inst, o_inst_pc, o_inst_valid, o_count,
        output i_imem_data, i_stall, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: issues word reads to a 1-cycle synchronous memory and
// queues {word, pc} pairs for the core; a redirect flushes everything and restarts at a new PC.
module fetch_prefetch_queue #(
    parameter int                  p_WORD_LEN = 16,
    parameter int                  p_ADDR_LEN = 16,
    parameter int                  p_DEPTH    = 4,
    parameter logic [p_ADDR_LEN-1:0] p_RESET_PC = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    fetch_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(p_DEPTH);
    localparam int CW = PW + 1;

    logic [p_ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [p_ADDR_LEN-1:0] infl_pc_q, infl_pc_d;
    logic                  infl_q, infl_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [p_DEPTH-1:0][p_WORD_LEN-1:0] word_q;
    logic [p_DEPTH-1:0][p_ADDR_LEN-1:0] pc_q;

    logic req, push, pop, empty;

    assign empty = (count_q == '0);

    // Credit counts the in-flight word but not this cycle's pop, keeping i_stall off the req path.
    assign req  = !i_rst && !bus.i_redirect && ((count_q + CW'(infl_q)) < CW'(p_DEPTH));
    assign push = infl_q && !bus.i_redirect;
    assign pop  = !empty && !bus.i_stall && !bus.i_redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        infl_pc_d  = infl_pc_q;
        infl_d     = infl_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (bus.i_redirect) begin
            fetch_pc_d = bus.i_redirect_pc;
            infl_d     = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            infl_d = req;
            if (req) begin
                fetch_pc_d = fetch_pc_q + 1'b1;
                infl_pc_d  = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_q <= p_RESET_PC;
            infl_pc_q  <= '0;
            infl_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_pc_q  <= infl_pc_d;
            infl_q     <= infl_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            word_q[wr_ptr_q] <= bus.i_imem_data;
            pc_q[wr_ptr_q]   <= infl_pc_q;
        end
    end

    assign bus.o_imem_req   = req;
    assign bus.o_imem_addr  = fetch_pc_q;
    assign bus.o_inst_valid = !empty;
    assign bus.o_inst       = empty ? '0 : word_q[rd_ptr_q];
    assign bus.o_inst_pc    = empty ? '0 : pc_q[rd_ptr_q];
    assign bus.o_count      = count_q;
endmodule
